perf_counter_ctrl: RTL
======================

PERF_COUNTER_CTRL -- requirements
Module: perf_counter_ctrl

Interface
REQ-001 SHALL have parameter NUM_CNT, default 16: number of counters managed, indices 0..NUM_CNT-1, range 2..32.
REQ-002 SHALL have port clk_i, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port csr_req_i, input, 1 bit: CSR access request.
REQ-005 SHALL have port csr_we_i, input, 1 bit: CSR access is a write.
REQ-006 SHALL have port csr_addr_i, input, 5 bits: counter index.
REQ-007 SHALL have port csr_wdata_i, input, 64 bits: CSR write data.
REQ-008 SHALL have port csr_gnt_o, output, 1 bit: access accepted this cycle.
REQ-009 SHALL have port csr_rvalid_o, output, 1 bit: read data valid.
REQ-010 SHALL have port csr_rdata_o, output, 64 bits: read data.
REQ-011 SHALL have port clear_all_i, input, 1 bit: pulse that starts zeroing of all counters.
REQ-012 SHALL have port busy_o, output, 1 bit: clear sequence in progress.
REQ-013 SHALL have port clear_done_o, output, 1 bit: one-cycle pulse when the clear sequence finishes.
REQ-014 SHALL have port pc_addr_o, output, 5 bits: counter array address.
REQ-015 SHALL have port pc_we_o, output, 1 bit: counter array write enable.
REQ-016 SHALL have port pc_wdata_o, output, 64 bits: counter array write data.
REQ-017 SHALL have port pc_rdata_i, input, 64 bits: combinational read of the counter array at pc_addr_o.
REQ-018 SHALL have port scan_en_i, input, 1 bit: enables the overflow scan.
REQ-019 SHALL have port thresh_i, input, 64 bits: overflow threshold; 0 disables detection.
REQ-020 SHALL have port ovf_clr_i, input, NUM_CNT bits: per-counter clear of the sticky overflow flag.
REQ-021 SHALL have port ovf_o, output, NUM_CNT bits: sticky overflow flags.
REQ-022 SHALL have port irq_o, output, 1 bit: registered OR of ovf_o.

Function
REQ-023 SHALL arbitrate the single counter-array port with fixed priority each cycle: CSR, then clear, then scan.
REQ-024 SHALL assert csr_gnt_o combinationally when csr_req_i is high, except for CSR writes while busy_o=1, which get gnt=0 and are held off until the clear sequence ends.
REQ-025 SHALL complete a granted read in one cycle: csr_rvalid_o=1 in the next cycle, with csr_rdata_o holding pc_rdata_i as sampled in the grant cycle.
REQ-026 SHALL drive pc_we_o=1 with csr_wdata_i in the grant cycle of a granted write; no rvalid is produced for a write.
REQ-027 SHALL, for csr_addr_i >= NUM_CNT, grant the access, return 0 on a read, and drop a write (pc_we_o=0).
REQ-028 SHALL implement FSM IDLE->CLEAR on clear_all_i in IDLE; clear_all_i while in CLEAR is ignored.
REQ-029 SHALL, in CLEAR, write 0 to index clr_ptr in each cycle not used by the CSR, then increment clr_ptr from 0 up to NUM_CNT-1.
REQ-030 SHALL leave CLEAR for IDLE after the write to index NUM_CNT-1, pulse clear_done_o in the cycle after that write, and reset clr_ptr to 0.
REQ-031 SHALL set busy_o=1 exactly while the FSM is in CLEAR.
REQ-032 SHALL, in IDLE with scan_en_i=1 and no CSR access, read index scan_ptr; scan_ptr increments and wraps from NUM_CNT-1 to 0.
REQ-033 SHALL set ovf_o[scan_ptr] when the scanned value >= thresh_i and thresh_i != 0.
REQ-034 SHALL clear ovf_o[i] on ovf_clr_i[i], on a CSR write to index i, or when the clear sequence zeroes index i; if set and clear coincide, set wins.
REQ-035 SHALL update irq_o one cycle after any change of ovf_o.

Reset
REQ-036 SHALL, while rst_i=1, set FSM=IDLE, clr_ptr=0, scan_ptr=0, ovf_o=0, and drive irq_o, csr_rvalid_o, csr_rdata_o, busy_o, clear_done_o and pc_we_o to 0.
REQ-037 SHALL abandon a clear sequence interrupted by reset; no clear_done_o pulse follows.

Configuration
REQ-038 SHALL include the scan/overflow logic of REQ-032..REQ-035 only when PERF_COUNTER_CTRL_SCAN_EN is defined; when it is undefined, ovf_o=0, irq_o=0, scan_en_i, thresh_i and ovf_clr_i are ignored, and the array port is never driven by the scan.

Verification
REQ-039 SHALL cover: CSR read of index 3 holding 0x55 -> gnt same cycle, rvalid next cycle, rdata=0x55.
REQ-040 SHALL cover: clear_all_i with NUM_CNT=16 and no CSR traffic -> 16 zero writes to indices 0..15, busy_o high for 16 cycles, then one clear_done_o pulse.
REQ-041 SHALL cover: CSR write to index 5 during CLEAR -> gnt=0 until busy_o falls, then granted, and index 5 ends at the written value.
REQ-042 SHALL cover: thresh_i=100 with counter 7 = 100 and scan enabled -> ovf_o[7]=1 within NUM_CNT+1 cycles, irq_o one cycle later; ovf_clr_i[7] -> both back to 0.
REQ-043 SHALL cover: CSR read of index 20 -> rdata=0; CSR write to index 20 -> pc_we_o stays 0.
REQ-044 SHALL cover: rst_i asserted mid-clear at clr_ptr=6 -> all outputs 0 immediately and no clear_done_o pulse.

Source files
------------

// File: rtl/perf_counter_ctrl.sv
// Performance-counter array controller: CSR access, sequenced clear-all and optional overflow scan.
// Define PERF_COUNTER_CTRL_SCAN_EN to build in the threshold scan, sticky overflow flags and irq.

module perf_counter_ctrl #(
   parameter int unsigned NUM_CNT = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               csr_req_i,
   input  logic               csr_we_i,
   input  logic [4:0]         csr_addr_i,
   input  logic [63:0]        csr_wdata_i,
   output logic               csr_gnt_o,
   output logic               csr_rvalid_o,
   output logic [63:0]        csr_rdata_o,
   input  logic               clear_all_i,
   output logic               busy_o,
   output logic               clear_done_o,
   output logic [4:0]         pc_addr_o,
   output logic               pc_we_o,
   output logic [63:0]        pc_wdata_o,
   input  logic [63:0]        pc_rdata_i,
   input  logic               scan_en_i,
   input  logic [63:0]        thresh_i,
   input  logic [NUM_CNT-1:0] ovf_clr_i,
   output logic [NUM_CNT-1:0] ovf_o,
   output logic               irq_o
);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
   localparam logic [4:0] LAST_IDX = 5'(NUM_CNT - 1);

   state_e     state_q, state_d;
   logic [4:0] clr_ptr_q, clr_ptr_d;
   logic       csr_in_range, csr_rd, csr_wr, clr_wr, clr_last;
   logic       scan_rd;
   logic [4:0] scan_addr;

   assign busy_o       = (state_q == ST_CLEAR);
   assign csr_in_range = ({1'b0, csr_addr_i} < 6'(NUM_CNT));
   // Writes are held off during a clear so they cannot be overwritten by a later zero write.
   assign csr_gnt_o    = csr_req_i && !(csr_we_i && busy_o);
   assign csr_rd       = csr_gnt_o && !csr_we_i;
   assign csr_wr       = csr_gnt_o && csr_we_i && csr_in_range;
   assign clr_wr       = busy_o && !csr_gnt_o;
   assign clr_last     = clr_wr && (clr_ptr_q == LAST_IDX);

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_all_i) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (clr_last) begin
               state_d   = ST_IDLE;
               clr_ptr_d = '0;
            end else if (clr_wr) begin
               clr_ptr_d = clr_ptr_q + 5'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pc_addr_o  = '0;
      pc_we_o    = 1'b0;
      pc_wdata_o = '0;
      if (csr_gnt_o) begin
         pc_addr_o = csr_addr_i;
         pc_we_o   = csr_wr;
         if (csr_wr) pc_wdata_o = csr_wdata_i;
      end else if (clr_wr) begin
         pc_addr_o = clr_ptr_q;
         pc_we_o   = 1'b1;
      end else if (scan_rd) begin
         pc_addr_o = scan_addr;
      end
      if (rst_i) pc_we_o = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         clr_ptr_q    <= '0;
         csr_rvalid_o <= 1'b0;
         csr_rdata_o  <= '0;
         clear_done_o <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_ptr_q    <= clr_ptr_d;
         csr_rvalid_o <= csr_rd;
         clear_done_o <= clr_last;
         if (csr_rd) csr_rdata_o <= csr_in_range ? pc_rdata_i : '0;
      end
   end

`ifdef PERF_COUNTER_CTRL_SCAN_EN
   logic [4:0]         scan_ptr_q;
   logic               scan_hit;
   logic [NUM_CNT-1:0] ovf_q, ovf_d;

   assign scan_rd   = (state_q == ST_IDLE) && scan_en_i && !csr_req_i;
   assign scan_addr = scan_ptr_q;
   assign scan_hit  = scan_rd && (thresh_i != '0) && (pc_rdata_i >= thresh_i);
   assign ovf_o     = ovf_q;

   // Set has priority over every clear source.
   always_comb begin
      ovf_d = ovf_q;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
         ovf_d[i] = (ovf_q[i] && !(ovf_clr_i[i]
                                   || (csr_wr && (csr_addr_i == 5'(i)))
                                   || (clr_wr && (clr_ptr_q == 5'(i)))))
                    || (scan_hit && (scan_ptr_q == 5'(i)));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scan_ptr_q <= '0;
         ovf_q      <= '0;
         irq_o      <= 1'b0;
      end else begin
         if (scan_rd) scan_ptr_q <= (scan_ptr_q == LAST_IDX) ? 5'd0 : scan_ptr_q + 5'd1;
         ovf_q <= ovf_d;
         irq_o <= |ovf_q;
      end
   end
`else
   logic unused_scan_inputs;

   assign scan_rd            = 1'b0;
   assign scan_addr          = '0;
   assign ovf_o              = '0;
   assign irq_o              = 1'b0;
   assign unused_scan_inputs = ^{scan_en_i, thresh_i, ovf_clr_i};
`endif

endmodule
